// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of an SDRAM controller, one single-word transaction at a time.
// Define SDRAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [9:0]  ACCESS_NUM     = 10'h001
) (
  input  logic        sdram_clock,
  input  logic        reset,
  input  logic        p0_request,
  input  logic        p1_request,
  input  logic        p0_write,
  input  logic        p1_write,
  input  logic [24:0] p0_address,
  input  logic [24:0] p1_address,
  input  logic [15:0] p0_data_in,
  input  logic [15:0] p1_data_in,
  output logic [15:0] p0_data_out,
  output logic [15:0] p1_data_out,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        access_error,
  output logic [24:0] access_address,
  output logic [9:0]  access_num,
  output logic [15:0] access_data_in,
  input  logic [15:0] access_data_out,
  output logic        write_request,
  output logic        read_request,
  input  logic        write_flag,
  input  logic        read_flag,
  input  logic        idle,
  output logic [1:0]  grant
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 10;
  localparam int unsigned CW = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REQUEST   = 3'd1;
  localparam logic [2:0] S_ACTIVE    = 3'd2;
  localparam logic [2:0] S_DONE      = 3'd3;
  localparam logic [2:0] S_ABORT     = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [1:0]    grant_d;
  logic          p0_ack_d, p1_ack_d, error_d, wreq_d, rreq_d;
  logic [AW-1:0] aaddr_d;
  logic [DW-1:0] adin_d;
  logic [NW-1:0] anum_d;
  logic [DW-1:0] p0_dout_d, p1_dout_d;
  logic          pick1, flag_match, in_req, finish;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif

  // Next state plus lookahead of every output so that outputs come straight from flops
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    grant_d    = grant;
    p0_dout_d  = p0_data_out;
    p1_dout_d  = p1_data_out;
    flag_match = wr_q ? write_flag : read_flag;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
    last_d     = last_q;
    pick1      = p1_request && (!p0_request || !last_q);
`else
    pick1      = p1_request && !p0_request;
`endif

    case (state_q)
      S_IDLE: begin
        if (idle && (p0_request || p1_request)) begin
          state_d = S_REQUEST;
          wr_d    = pick1 ? p1_write   : p0_write;
          addr_d  = pick1 ? p1_address : p0_address;
          din_d   = pick1 ? p1_data_in : p0_data_in;
          cnt_d   = '0;
          grant_d = pick1 ? 2'b10 : 2'b01;
        end
      end
      S_REQUEST: begin
        // read data can arrive on the very cycle the controller accepts
        if (flag_match) begin
          state_d = S_ACTIVE;
          if (!wr_q) cap_d = access_data_out;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ACTIVE: begin
        if (!wr_q && read_flag) cap_d = access_data_out;
        if (!flag_match) state_d = S_DONE;
      end
      S_DONE, S_ABORT: begin
        state_d = S_WAIT_IDLE;
        grant_d = 2'b00;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
        last_d  = grant[1];
`endif
      end
      S_WAIT_IDLE: begin
        if (idle) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase

    in_req   = (state_d == S_REQUEST);
    finish   = (state_d == S_DONE) || (state_d == S_ABORT);
    wreq_d   = in_req && wr_d;
    rreq_d   = in_req && !wr_d;
    aaddr_d  = in_req ? addr_d : '0;
    adin_d   = in_req ? din_d : '0;
    anum_d   = in_req ? ACCESS_NUM : '0;
    p0_ack_d = finish && grant_d[0];
    p1_ack_d = finish && grant_d[1];
    error_d  = (state_d == S_ABORT);
    if (state_d == S_DONE && !wr_d) begin
      if (grant_d[0]) p0_dout_d = cap_d;
      if (grant_d[1]) p1_dout_d = cap_d;
    end
  end

  always_ff @(posedge sdram_clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      din_q          <= '0;
      cnt_q          <= '0;
      cap_q          <= '0;
      grant          <= 2'b00;
      p0_ack         <= 1'b0;
      p1_ack         <= 1'b0;
      access_error   <= 1'b0;
      write_request  <= 1'b0;
      read_request   <= 1'b0;
      access_address <= '0;
      access_data_in <= '0;
      access_num     <= '0;
      p0_data_out    <= '0;
      p1_data_out    <= '0;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      last_q         <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      cnt_q          <= cnt_d;
      cap_q          <= cap_d;
      grant          <= grant_d;
      p0_ack         <= p0_ack_d;
      p1_ack         <= p1_ack_d;
      access_error   <= error_d;
      write_request  <= wreq_d;
      read_request   <= rreq_d;
      access_address <= aaddr_d;
      access_data_in <= adin_d;
      access_num     <= anum_d;
      p0_data_out    <= p0_dout_d;
      p1_data_out    <= p1_dout_d;
`ifdef SDRAM_ARBITER_ROUND_ROBIN_EN
      last_q         <= last_d;
`endif
    end
  end

endmodule
